// File: rtl/bundler_multi.sv
// Multi-class HDC bundler: bipolar votes into per-class saturating counters, PAR_BITS dims/cycle.
// Optional sticky saturation flag enabled by defining BUNDLER_MULTI_SAT_FLAG_EN.
module bundler_multi #(
   parameter int unsigned DIMENSIONS  = 6,
   parameter int unsigned PAR_BITS    = 2,
   parameter int unsigned NUM_CLASSES = 2,
   parameter int unsigned CTR_W       = 3,
   parameter int unsigned CNT_W       = 8,
   localparam int unsigned CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [CLS_W-1:0]      class_sel,
   input  logic [DIMENSIONS-1:0] hv_train,
   output logic                  busy,
   output logic                  done,
   output logic [DIMENSIONS-1:0] hv_out,
   output logic [CNT_W-1:0]      vec_count,
   output logic                  sat
);

   if ((DIMENSIONS % PAR_BITS) != 0 || NUM_CLASSES < 1 || CTR_W < 2) begin : g_param_check
      $error("bundler_multi: DIMENSIONS must be a multiple of PAR_BITS, NUM_CLASSES>=1, CTR_W>=2");
   end

   localparam int unsigned NChunks = DIMENSIONS / PAR_BITS;
   localparam int unsigned IdxW    = (NChunks > 1) ? $clog2(NChunks) : 1;
   localparam int unsigned DimW    = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

   // Symmetric bounds: +(2^(CTR_W-1)-1) and its two's-complement negation.
   localparam logic [CTR_W-1:0] CtrMax = {1'b0, {(CTR_W - 1){1'b1}}};
   localparam logic [CTR_W-1:0] CtrMin = ~CtrMax + CTR_W'(1);
   localparam logic [CTR_W-1:0] CtrOne = CTR_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

   state_e                                          state_q, state_d;
   logic [NUM_CLASSES-1:0][DIMENSIONS-1:0][CTR_W-1:0] ctr_q, ctr_d;
   logic [NUM_CLASSES-1:0][CNT_W-1:0]               cnt_q, cnt_d;
   logic [DIMENSIONS-1:0]                           hv_lat_q, hv_lat_d;
   logic [CLS_W-1:0]                                cls_q, cls_d;
   logic [IdxW-1:0]                                 idx_q, idx_d;
   logic [DIMENSIONS-1:0]                           hv_out_q, hv_out_d;
   logic [CNT_W-1:0]                                vec_count_q, vec_count_d;

   logic             cls_ok;
   logic [DimW-1:0]  bit_idx;
   logic             vote;
   logic [CTR_W-1:0] c_cur, c_new;
   logic [CNT_W-1:0] cnt_cur;

   assign cls_ok = (32'(class_sel) < NUM_CLASSES);

`ifdef BUNDLER_MULTI_SAT_FLAG_EN
   logic sat_q, sat_d;
`endif

   always_comb begin
      state_d     = state_q;
      ctr_d       = ctr_q;
      cnt_d       = cnt_q;
      hv_lat_d    = hv_lat_q;
      cls_d       = cls_q;
      idx_d       = idx_q;
      hv_out_d    = hv_out_q;
      vec_count_d = vec_count_q;
      bit_idx     = '0;
      vote        = 1'b0;
      c_cur       = '0;
      c_new       = '0;
      cnt_cur     = '0;
`ifdef BUNDLER_MULTI_SAT_FLAG_EN
      sat_d       = sat_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (cls_ok) begin
               if (clr) begin
                  ctr_d[class_sel] = '0;
                  cnt_d[class_sel] = '0;
               end else if (en) begin
                  hv_lat_d = hv_train;
                  cls_d    = class_sel;
                  idx_d    = '0;
                  state_d  = StAccum;
`ifdef BUNDLER_MULTI_SAT_FLAG_EN
                  sat_d    = 1'b0;
`endif
               end
            end
         end
         StAccum: begin
            for (int unsigned p = 0; p < PAR_BITS; p++) begin
               bit_idx = DimW'(32'(idx_q) * PAR_BITS + p);
               vote    = hv_lat_q[bit_idx];
               c_cur   = ctr_q[cls_q][bit_idx];
               if (vote) c_new = (c_cur == CtrMax) ? c_cur : c_cur + CtrOne;
               else      c_new = (c_cur == CtrMin) ? c_cur : c_cur - CtrOne;
`ifdef BUNDLER_MULTI_SAT_FLAG_EN
               if ((vote && c_cur == CtrMax) || (!vote && c_cur == CtrMin)) sat_d = 1'b1;
`endif
               ctr_d[cls_q][bit_idx] = c_new;
               // A zero counter is a tie; the newest vector decides.
               hv_out_d[bit_idx] = (c_new == '0) ? vote : ~c_new[CTR_W-1];
            end
            if (idx_q == IdxW'(NChunks - 1)) begin
               cnt_cur      = cnt_q[cls_q];
               cnt_d[cls_q] = (cnt_cur == CntMax) ? cnt_cur : cnt_cur + CNT_W'(1);
               vec_count_d  = cnt_d[cls_q];
               state_d      = StDone;
            end else begin
               idx_d = idx_q + IdxW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= StIdle;
         ctr_q       <= '0;
         cnt_q       <= '0;
         hv_lat_q    <= '0;
         cls_q       <= '0;
         idx_q       <= '0;
         hv_out_q    <= '0;
         vec_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ctr_q       <= ctr_d;
         cnt_q       <= cnt_d;
         hv_lat_q    <= hv_lat_d;
         cls_q       <= cls_d;
         idx_q       <= idx_d;
         hv_out_q    <= hv_out_d;
         vec_count_q <= vec_count_d;
      end
   end

`ifdef BUNDLER_MULTI_SAT_FLAG_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) sat_q <= 1'b0;
      else       sat_q <= sat_d;
   end
   assign sat = sat_q;
`else
   assign sat = 1'b0;
`endif

   assign busy      = (state_q != StIdle);
   assign done      = (state_q == StDone);
   assign hv_out    = hv_out_q;
   assign vec_count = vec_count_q;

endmodule

// File: tb/tb_bundler_multi.sv
// Self-checking bench for bundler_multi: vector table plus scoreboard queue of expected results.
module tb_bundler_multi;

   localparam int unsigned Dim  = 6;
   localparam int unsigned ClsW = 1;
   localparam int unsigned CntW = 8;
`ifdef BUNDLER_MULTI_SAT_FLAG_EN
   localparam bit SatEn = 1'b1;
`else
   localparam bit SatEn = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            nrst, en, clr;
   logic [ClsW-1:0] class_sel;
   logic [Dim-1:0]  hv_train;
   logic            busy, done, sat;
   logic [Dim-1:0]  hv_out;
   logic [CntW-1:0] vec_count;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [Dim-1:0]  hv;
      logic [CntW-1:0] cnt;
      logic            sat;
   } exp_t;

   typedef struct packed {
      logic [ClsW-1:0] cls;
      logic [Dim-1:0]  hv;
      logic [Dim-1:0]  exp_hv;
      logic [CntW-1:0] exp_cnt;
      logic            clip;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[5];

   bundler_multi dut (
      .clk       (clk),
      .nrst      (nrst),
      .en        (en),
      .clr       (clr),
      .class_sel (class_sel),
      .hv_train  (hv_train),
      .busy      (busy),
      .done      (done),
      .hv_out    (hv_out),
      .vec_count (vec_count),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Runs one pass; returns on the negedge of the first IDLE cycle after done.
   task automatic bundle(input logic [ClsW-1:0] cls, input logic [Dim-1:0] hv,
                         input exp_t e, input bit hold_en);
      int   n;
      int   busy_n;
      bit   seen;
      exp_t got;
      sb_q.push_back(e);
      @(posedge clk); #1;
      en        = 1'b1;
      class_sel = cls;
      hv_train  = hv;
      @(posedge clk); #1;
      if (!hold_en) begin
         en        = 1'b0;
         hv_train  = ~hv;
         class_sel = ~cls;
      end
      n      = 0;
      busy_n = 0;
      seen   = 1'b0;
      while (n < 10 && !seen) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done) seen = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      en = 1'b0;
      check("done_seen", 32'(seen), 32'd1);
      check("done_latency", n, 3);
      check("busy_cycles", busy_n, 4);
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_empty: got 0 entries, want 1");
      end else begin
         got = sb_q.pop_front();
         check("hv_out", 32'(hv_out), 32'(got.hv));
         check("vec_count", 32'(vec_count), 32'(got.cnt));
         check("sat", 32'(sat), 32'(got.sat));
      end
      @(posedge clk);
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{cls: 1'b0, hv: 6'b100001, exp_hv: 6'b100001, exp_cnt: 8'd1, clip: 1'b0};
      vecs[1] = '{cls: 1'b0, hv: 6'b110001, exp_hv: 6'b110001, exp_cnt: 8'd2, clip: 1'b0};
      vecs[2] = '{cls: 1'b0, hv: 6'b111111, exp_hv: 6'b110001, exp_cnt: 8'd3, clip: 1'b0};
      vecs[3] = '{cls: 1'b1, hv: 6'b000000, exp_hv: 6'b000000, exp_cnt: 8'd1, clip: 1'b0};
      vecs[4] = '{cls: 1'b0, hv: 6'b111111, exp_hv: 6'b111111, exp_cnt: 8'd4, clip: 1'b1};

      nrst      = 1'b0;
      en        = 1'b0;
      clr       = 1'b0;
      class_sel = '0;
      hv_train  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("rst_hv_out", 32'(hv_out), 32'd0);
      check("rst_vec_count", 32'(vec_count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sat", 32'(sat), 32'd0);

      for (int i = 0; i < 5; i++) begin
         bundle(vecs[i].cls, vecs[i].hv,
                '{hv: vecs[i].exp_hv, cnt: vecs[i].exp_cnt, sat: vecs[i].clip & SatEn}, 1'b0);
      end

      // en held through the whole pass must start only one pass.
      bundle(1'b1, 6'b111111, '{hv: 6'b111111, cnt: 8'd2, sat: 1'b0}, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_en_idle", 32'(busy), 32'd0);
      end
      check("hold_en_count", 32'(vec_count), 32'd2);

      // clr beats en in the same IDLE cycle.
      @(posedge clk); #1;
      clr       = 1'b1;
      en        = 1'b1;
      class_sel = 1'b1;
      hv_train  = 6'b000000;
      @(posedge clk); #1;
      clr = 1'b0;
      en  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("clr_en_busy", 32'(busy), 32'd0);
         check("clr_en_done", 32'(done), 32'd0);
      end
      bundle(1'b1, 6'b010101, '{hv: 6'b010101, cnt: 8'd1, sat: 1'b0}, 1'b0);

      // Reset partway through a pass.
      @(posedge clk); #1;
      en        = 1'b1;
      class_sel = 1'b0;
      hv_train  = 6'b010101;
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b0;
      #1;
      check("midrst_hv_out", 32'(hv_out), 32'd0);
      check("midrst_vec_count", 32'(vec_count), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sat", 32'(sat), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      bundle(1'b0, 6'b101010, '{hv: 6'b101010, cnt: 8'd1, sat: 1'b0}, 1'b0);

      check("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bundler_multi.md
Name: bundler_multi

Overview:
- Parametrised successor to the continuous-training bundler for the HDC seizure-detection pipeline.
- Accumulates bipolar votes for training hypervectors into NUM_CLASSES independent class accumulators, e.g. seizure and non-seizure prototypes.
- Processes PAR_BITS dimensions per cycle using saturating signed counters.
- Emits the thresholded prototype of the class just updated, together with a per-class bundle count.

Parameters:
- DIMENSIONS, 6, hypervector width in bits. Must be a multiple of PAR_BITS; elaboration fails otherwise.
- PAR_BITS, 2, dimensions updated per clock.
- NUM_CLASSES, 2, number of independent class accumulators (≥1).
- CTR_W, 3, signed counter width per dimension per class (≥2).
- CNT_W, 8, width of the per-class bundled-vector counter.

Ports:
- clk  in  1  rising-edge clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  start pulse; sampled only in IDLE
- clr  in  1  clear selected class; sampled only in IDLE
- class_sel  in  max(1,$clog2(NUM_CLASSES))  target class, latched with en/clr
- hv_train  in  DIMENSIONS  training hypervector, latched with en
- busy  out  1  high in ACCUM and DONE
- done  out  1  one-cycle pulse when hv_out/vec_count are valid
- hv_out  out  DIMENSIONS  thresholded prototype of last-updated class
- vec_count  out  CNT_W  vectors bundled into last-updated class
- sat  out  1  saturation flag (see Optional Feature)

Behaviour:
- Reset (async, nrst=0):
  - State goes to IDLE.
  - All counters, class counts, hv_out, vec_count, done, busy and sat go to 0.
  - Reset mid-ACCUM abandons the pass; no partial update survives.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - clr=1: clears all DIMENSIONS counters and the count of class_sel in one edge, then stays in IDLE.
  - clr=1 and en=1 on the same edge: clr wins and en is dropped.
  - en=1 (clr=0): latches hv_train and class_sel, sets chunk index to 0, moves to ACCUM.
  - class_sel ≥ NUM_CLASSES: en/clr ignored.
- ACCUM, one chunk per edge, for N_CHUNKS = DIMENSIONS/PAR_BITS edges:
  - Chunk k covers bits [k*PAR_BITS +: PAR_BITS].
  - Each counter c moves to c+1 if the latched bit is 1, else c-1.
  - Counters saturate symmetrically at ±(2^(CTR_W-1)-1).
  - In the same edge, hv_out bits of chunk k are written: 1 if the new c>0, 0 if c<0, and the latched bit if c==0 (tie goes to the newest vector).
  - After chunk N_CHUNKS-1: increment the class count (saturating at 2^CNT_W-1), load vec_count, move to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - done rises N_CHUNKS edges after the edge that sampled en.
  - Next en is accepted on the edge ending DONE+1, i.e. first IDLE cycle; throughput is one vector per N_CHUNKS+2 cycles.
- en/clr/hv_train changes while busy: ignored; the latched copy is used.
- hv_out and vec_count hold between passes.
- hv_out bits of not-yet-processed chunks still show the previous pass until done.
- Bundling a single vector into a cleared class gives hv_out == hv_train.

Optional Feature:
- Macro: BUNDLER_MULTI_SAT_FLAG_EN.
- Defined:
  - sat is cleared on en acceptance.
  - sat is set in ACCUM if any counter update was clipped at a saturation bound during the pass.
  - sat is valid with done and holds until the next en.
- Undefined: sat is tied to 0 and no saturation-detect logic is built.
- Counter saturation itself is always present.

Test Plan:
- Reset: nrst=0 then 1 -> hv_out=000000, vec_count=0, done=0, busy=0, sat=0.
- Single vector (defaults): en with class 0, hv_train=100001 -> busy for 4 cycles, done pulses exactly 3 edges after the en-sampling edge, hv_out=100001, vec_count=1.
- Majority/tie, class 0 continued:
  - 110001 -> hv_out=110001 (bit4 tie resolves to 1), vec_count=2.
  - Then 111111 -> hv_out=110001, vec_count=3.
- Class isolation and saturation:
  - 000000 to class 1 -> hv_out=000000, vec_count=1.
  - Then 111111 to class 0 -> hv_out=111111, vec_count=4.
  - sat=1 with macro defined (bit5/bit0 clipped at +3); sat=0 without.
- Handshake:
  - en held high through ACCUM -> only one pass, vec_count increments by 1.
  - clr=1 and en=1 together in IDLE -> class cleared, no pass, busy stays 0.
- Reset mid-ACCUM: nrst pulsed at chunk 1 -> all outputs 0 immediately; next bundle of 101010 into class 0 -> hv_out=101010, vec_count=1.
